// File: rtl/conv_pkg.sv
// Shared widths and helpers for the convolver MAC pipeline: product/accumulator
// sizing, packed tap extraction, and operand sign/zero extension.
package conv_pkg;

  // Widest packed tap vector the slice helper accepts.
  localparam int MAX_VEC_W = 1024;

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int acc_w(input int taps, input int dw, input int cw, input int mb);
    return dw + cw + $clog2(taps) + $clog2(mb);
  endfunction

  function automatic logic [63:0] tap_slice(input logic [MAX_VEC_W-1:0] vec, input int idx,
                                            input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return 64'(vec >> (idx * w)) & mask;
  endfunction

  // Treats the low w bits of v as the value; replicates bit w-1 above it when sgn is set.
  function automatic logic [63:0] extend(input logic [63:0] v, input int w, input bit sgn);
    logic [63:0] mask;
    logic        neg;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    neg  = sgn && (((v >> (w - 1)) & 64'd1) != 64'd0);
    return neg ? (v | ~mask) : (v & mask);
  endfunction

endpackage

// File: rtl/conv_add_tree.sv
// Combinational binary adder tree reducing N packed IN_W terms to one OUT_W sum.
// Terms are sign- or zero-extended to OUT_W before the first level.
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int N      = 9,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 14,
  parameter int SIGNED = 0
) (
  input  logic [N*IN_W-1:0] i_terms,
  output logic [OUT_W-1:0]  o_sum
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int LEAVES = 1 << LEVELS;

  // Each level is its own array so no signal feeds back into itself.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int WIDTH = LEAVES >> lv;
    logic [OUT_W-1:0] w_val [WIDTH];
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (gi < N) begin : g_term
          assign w_val[gi] = OUT_W'(extend(tap_slice(MAX_VEC_W'(i_terms), gi, IN_W), IN_W,
                                           SIGNED != 0));
        end else begin : g_pad
          assign w_val[gi] = '0;
        end
      end else begin : g_sum
        assign w_val[gi] = g_lvl[lv-1].w_val[2*gi] + g_lvl[lv-1].w_val[2*gi+1];
      end
    end
  end

  assign o_sum = g_lvl[LEVELS].w_val[0];

endmodule

// File: rtl/conv_mac_pipe.sv
// Two-stage pipelined multiply-accumulate over multi-beat groups with valid/ready output.
// Define CONV_MAC_SAT_EN to clip narrow results (and flag out_sat) instead of wrapping.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int NUM_TAPS  = 9,
  parameter int DATA_W    = 4,
  parameter int COEFF_W   = 4,
  parameter int SIGNED    = 0,
  parameter int MAX_BEATS = 4,
  parameter int OUT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coeff_load,
  input  logic [NUM_TAPS*COEFF_W-1:0] coeff_in,
  input  logic [NUM_TAPS*DATA_W-1:0]  sample_in,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_err,
  output logic                        out_sat
);

  localparam int PROD_W = prod_w(DATA_W, COEFF_W);
  localparam int ACC_W  = acc_w(NUM_TAPS, DATA_W, COEFF_W, MAX_BEATS);
  localparam int CNT_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam bit SGN    = (SIGNED != 0);

  logic [NUM_TAPS*COEFF_W-1:0] r_coeff;
  logic [NUM_TAPS*PROD_W-1:0]  r_prod;
  logic [NUM_TAPS*PROD_W-1:0]  w_prod;
  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic [ACC_W-1:0]            r_acc;
  logic [ACC_W-1:0]            w_sum;
  logic [ACC_W-1:0]            w_total;
  logic [CNT_W-1:0]            r_beat_cnt;
  logic [OUT_W-1:0]            r_out_data;
  logic [OUT_W-1:0]            w_fit_data;
  logic                        r_out_valid;
  logic                        r_out_err;
  logic                        w_stall;
  logic                        w_accept;
  logic                        w_s2_fire;
  logic                        w_close;

  assign w_stall   = r_out_valid && !out_ready;
  assign in_ready  = !w_stall;
  assign w_accept  = in_valid && !w_stall;
  assign w_s2_fire = r_s1_valid && !w_stall;
  assign w_close   = r_s1_last || (r_beat_cnt == CNT_W'(MAX_BEATS - 1));

  // Operands are widened to the product width first so the low bits are exact in both modes.
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_mul
    logic [PROD_W-1:0] w_s;
    logic [PROD_W-1:0] w_c;
    assign w_s = PROD_W'(extend(tap_slice(MAX_VEC_W'(sample_in), gi, DATA_W), DATA_W, SGN));
    assign w_c = PROD_W'(extend(tap_slice(MAX_VEC_W'(r_coeff), gi, COEFF_W), COEFF_W, SGN));
    assign w_prod[gi*PROD_W +: PROD_W] = w_s * w_c;
  end

  conv_add_tree #(
    .N      (NUM_TAPS),
    .IN_W   (PROD_W),
    .OUT_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .i_terms (r_prod),
    .o_sum   (w_sum)
  );

  assign w_total = r_acc + w_sum;

`ifdef CONV_MAC_SAT_EN
  logic w_fit_sat;
  logic r_out_sat;
`endif

  if (OUT_W >= ACC_W) begin : g_fit_ext
    assign w_fit_data = OUT_W'(extend(64'(w_total), ACC_W, SGN));
`ifdef CONV_MAC_SAT_EN
    assign w_fit_sat = 1'b0;
`endif
  end else begin : g_fit_narrow
`ifdef CONV_MAC_SAT_EN
    if (SIGNED != 0) begin : g_sgn
      // Fits when every bit from OUT_W-1 upward matches the sign.
      logic w_fits;
      assign w_fits     = (w_total[ACC_W-1:OUT_W-1] == '0) || (w_total[ACC_W-1:OUT_W-1] == '1);
      assign w_fit_sat  = !w_fits;
      assign w_fit_data = w_fits ? w_total[OUT_W-1:0]
                                 : {w_total[ACC_W-1], {(OUT_W-1){!w_total[ACC_W-1]}}};
    end else begin : g_uns
      assign w_fit_sat  = (w_total[ACC_W-1:OUT_W] != '0);
      assign w_fit_data = w_fit_sat ? '1 : w_total[OUT_W-1:0];
    end
`else
    assign w_fit_data = w_total[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coeff     <= '0;
      r_prod      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
`ifdef CONV_MAC_SAT_EN
      r_out_sat   <= 1'b0;
`endif
    end else begin
      // The bank write is visible to S1 only from the next accepted beat.
      if (coeff_load) r_coeff <= coeff_in;
      if (!w_stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_prod    <= w_prod;
          r_s1_last <= in_last;
        end
      end
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_s2_fire) begin
        if (w_close) begin
          r_out_data  <= w_fit_data;
          r_out_valid <= 1'b1;
          r_out_err   <= !r_s1_last;
`ifdef CONV_MAC_SAT_EN
          r_out_sat   <= w_fit_sat;
`endif
          r_acc       <= '0;
          r_beat_cnt  <= '0;
        end else begin
          r_acc      <= w_total;
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_err   = r_out_err;
`ifdef CONV_MAC_SAT_EN
  assign out_sat   = r_out_sat;
`else
  assign out_sat   = 1'b0;
`endif

endmodule
